register_file: RTL and testbench
================================

Name: register_file

Overview:
- Operand register file directly upstream of the ALU; drives its A and B inputs through OutA/OutB.
- Holds 4 general-purpose registers R1..R4 and 4 scratch registers S1..S4, each WIDTH bits.
- Per-cycle register operation is selected by FunSel and applied in parallel to every enabled register.
- Also accepts the ALU result on I, closing the datapath loop.

Parameters:
- WIDTH, 32, register and port data width; must be >= 16.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- I  input  WIDTH  load data (ALU result, memory data or immediate)
- FunSel  input  3  register operation, applied to all enabled registers
- RegSel  input  4  one-hot-or-more enables; bit0=R1, bit1=R2, bit2=R3, bit3=R4; 1 = enabled
- ScrSel  input  4  enables; bit0=S1, bit1=S2, bit2=S3, bit3=S4; 1 = enabled
- OutASel  input  3  read select A: 000..011 = R1..R4, 100..111 = S1..S4
- OutBSel  input  3  read select B, same encoding as OutASel
- OutA  output  WIDTH  ALU operand A
- OutB  output  WIDTH  ALU operand B

Behaviour:
- One clock (Clock); reset is synchronous and active-high (Reset).
- Reset:
  - On a rising edge with Reset=1, all 8 registers load 0 and all FunSel/RegSel/ScrSel activity is ignored.
  - OutA and OutB therefore read 0 from the cycle after reset.
  - Reset asserted mid-sequence discards any in-progress multi-cycle load.
- Write: on a rising edge with Reset=0, every register whose enable bit is 1 updates per FunSel. Registers whose enable bit is 0 hold their value.
- FunSel operations:
  - 000: decrement by 1, modulo 2^WIDTH; 0 wraps to all-ones.
  - 001: increment by 1, modulo 2^WIDTH; all-ones wraps to 0.
  - 010: load I.
  - 011: clear to 0.
  - 100: clear, then write low byte: Q = {0, I[7:0]}.
  - 101: load low 16 bits of I zero-extended: Q = {0, I[15:0]}.
  - 110: load low 16 bits of I sign-extended from I[15].
  - 111: shift-in byte: Q = {Q[WIDTH-9:0], I[7:0]}. Four consecutive cycles assemble a 32-bit word, MSB byte first.
- RegSel=0000 and ScrSel=0000: no write; FunSel is ignored.
- Multiple enable bits set: all enabled registers perform the same operation in the same cycle. Each register uses its own old value for 000, 001 and 111.
- Reads:
  - OutA and OutB are combinational from current register contents (value before the pending edge).
  - Zero-latency select: a change on OutASel/OutBSel is visible in the same cycle.
  - OutASel == OutBSel is legal; both outputs carry the same register.
- Read-during-write: with the macro absent, an output shows the old value in the write cycle and the new value after the edge.
- Latency: write to read-visible is 1 cycle.
- No X propagation: every select code is defined.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - OutA/OutB show the next-state value of the selected register whenever that register is enabled in the current cycle and Reset=0.
  - This covers all FunSel operations, including inc/dec/shift.
  - Write-then-use then costs 0 cycles.
  - With Reset=1, outputs show current contents, not 0.
- Absent: outputs always show current stored contents, as specified under Behaviour.

Test Plan:
- Reset then read: assert Reset for 1 edge; sweep OutASel 000..111 -> OutA = 0 for all 8 registers; OutB identical.
- Load and sign-extend: I=0x0000_8001, FunSel=010, RegSel=0001 -> R1=0x0000_8001. FunSel=110, ScrSel=0010 -> S2=0xFFFF_8001. FunSel=101 on R3 -> R3=0x0000_8001.
- Wrap-around: clear R2 (FunSel=011), then FunSel=000 -> R2=0xFFFF_FFFF. Then FunSel=001 -> R2=0x0000_0000.
- Byte assembly: clear S4; four edges of FunSel=111 with I[7:0]=0xDE,0xAD,0xBE,0xEF, ScrSel=1000 -> S4=0xDEADBEEF. Assert Reset after the second byte -> S4=0 and the sequence is abandoned.
- Parallel write and isolation: R1=5, R4=9, FunSel=001, RegSel=1001 -> R1=6, R4=10. R2, R3 and all scratch registers are unchanged; RegSel=0000 with FunSel=011 changes nothing.
- Read-during-write: OutASel=000, R1=0x10, FunSel=010, I=0x20, RegSel=0001:
  - Macro absent: OutA=0x10 in the write cycle, 0x20 after the edge.
  - REGFILE_BYPASS_EN defined: OutA=0x20 in the write cycle.

Source files
------------

// File: rtl/register_file.sv
// register_file: operand register file feeding the ALU A/B inputs.
//
// Holds four general-purpose registers R1..R4 and four scratch registers
// S1..S4. Every enabled register applies the FunSel operation on each rising
// Clock edge; disabled registers hold their value. Reads are combinational.
//
// Ports:
//   Clock    - rising-edge clock
//   Reset    - synchronous, active-high; clears all eight registers
//   I        - load data (ALU result, memory data or immediate)
//   FunSel   - register operation applied to every enabled register
//   RegSel   - enables for R1..R4 (bit0 = R1)
//   ScrSel   - enables for S1..S4 (bit0 = S1)
//   OutASel  - read select A: 0..3 = R1..R4, 4..7 = S1..S4
//   OutBSel  - read select B, same encoding
//   OutA     - ALU operand A
//   OutB     - ALU operand B
//
// Optional feature, macro REGFILE_BYPASS_EN:
//   When defined, OutA/OutB forward the next-state value of a register that is
//   enabled in the current cycle (Reset low), so write-then-use costs no cycle.
//   When undefined, outputs always show the stored contents.

module register_file #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  localparam int unsigned NumRegs = 8;

  // The byte shift and 16-bit loads need at least 16 bits of storage.
  if (WIDTH < 16) begin : gen_width_check
    $error("register_file: WIDTH must be >= 16");
  end

  typedef enum logic [2:0] {
    OpDec     = 3'b000,
    OpInc     = 3'b001,
    OpLoad    = 3'b010,
    OpClear   = 3'b011,
    OpLoadB   = 3'b100,
    OpLoadHZ  = 3'b101,
    OpLoadHS  = 3'b110,
    OpShiftB  = 3'b111
  } fun_sel_e;

  logic [WIDTH-1:0] regs_q [NumRegs];
  logic [WIDTH-1:0] regs_d [NumRegs];
  logic [WIDTH-1:0] rd_view [NumRegs];
  logic [NumRegs-1:0] reg_en;

  // Index order matches the read-select encoding: R1..R4 then S1..S4.
  assign reg_en = {ScrSel, RegSel};

  function automatic logic [WIDTH-1:0] op_result(input logic [2:0]       op,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] res;
    res = '0;
    case (fun_sel_e'(op))
      OpDec:    res = q - WIDTH'(1);
      OpInc:    res = q + WIDTH'(1);
      OpLoad:   res = d;
      OpClear:  res = '0;
      OpLoadB:  res = WIDTH'(d[7:0]);
      OpLoadHZ: res = WIDTH'(d[15:0]);
      OpLoadHS: res = WIDTH'($signed(d[15:0]));
      OpShiftB: res = {q[WIDTH-9:0], d[7:0]};
      default:  res = '0;
    endcase
    return res;
  endfunction

  // Each enabled register uses its own old value, so parallel inc/dec/shift
  // operate independently.
  always_comb begin
    for (int k = 0; k < NumRegs; k++) begin
      regs_d[k] = regs_q[k];
      if (reg_en[k]) begin
        regs_d[k] = op_result(FunSel, regs_q[k], I);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < NumRegs; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumRegs; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // regs_d equals regs_q for disabled registers, so forwarding regs_d covers
  // exactly the enabled ones. During Reset the stored contents are shown.
  always_comb begin
    for (int k = 0; k < NumRegs; k++) begin
`ifdef REGFILE_BYPASS_EN
      rd_view[k] = Reset ? regs_q[k] : regs_d[k];
`else
      rd_view[k] = regs_q[k];
`endif
    end
  end

  assign OutA = rd_view[OutASel];
  assign OutB = rd_view[OutBSel];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam int unsigned W = 32;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [W-1:0] I;
  logic [2:0]   FunSel;
  logic [3:0]   RegSel;
  logic [3:0]   ScrSel;
  logic [2:0]   OutASel;
  logic [2:0]   OutBSel;
  logic [W-1:0] OutA;
  logic [W-1:0] OutB;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m [8];

  register_file #(.WIDTH(W)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .I      (I),
    .FunSel (FunSel),
    .RegSel (RegSel),
    .ScrSel (ScrSel),
    .OutASel(OutASel),
    .OutBSel(OutBSel),
    .OutA   (OutA),
    .OutB   (OutB)
  );

  always #10 Clock = ~Clock;

  function automatic logic [W-1:0] model_op(input logic [2:0] op, input logic [W-1:0] q,
                                            input logic [W-1:0] d);
    case (op)
      3'd0: return q - 1;
      3'd1: return q + 1;
      3'd2: return d;
      3'd3: return 0;
      3'd4: return d & 32'h0000_00ff;
      3'd5: return d & 32'h0000_ffff;
      3'd6: return d[15] ? (d | 32'hffff_0000) : (d & 32'h0000_ffff);
      default: return (q << 8) | (d & 32'h0000_00ff);
    endcase
  endfunction

  function automatic logic model_en(input int k);
    logic [7:0] en;
    en = {ScrSel, RegSel};
    return en[k];
  endfunction

  function automatic logic [W-1:0] model_out(input logic [2:0] sel);
`ifdef REGFILE_BYPASS_EN
    if (!Reset && model_en(int'(sel))) return model_op(FunSel, m[sel], I);
`endif
    return m[sel];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model update at the edge, using the inputs that were held across it.
  task automatic model_step();
    for (int k = 0; k < 8; k++) begin
      if (Reset) m[k] = 0;
      else if (model_en(k)) m[k] = model_op(FunSel, m[k], I);
    end
  endtask

  // Drive one cycle: random read selects checked before the edge, then clock.
  task automatic apply(input logic r, input logic [2:0] fs, input logic [3:0] rs,
                       input logic [3:0] ss, input logic [W-1:0] d);
    Reset = r; FunSel = fs; RegSel = rs; ScrSel = ss; I = d;
    OutASel = 3'($urandom); OutBSel = 3'($urandom);
    #1;
    check("outa_cycle", OutA, model_out(OutASel));
    check("outb_cycle", OutB, model_out(OutBSel));
    @(posedge Clock);
    model_step();
    #1;
  endtask

  // Idle the enables and read one register on both ports against a constant.
  task automatic read_check(input string tag, input logic [2:0] sel, input logic [W-1:0] exp);
    Reset = 1'b0; RegSel = 4'b0; ScrSel = 4'b0;
    OutASel = sel; OutBSel = sel;
    #1;
    check({tag, "_a"}, OutA, exp);
    check({tag, "_b"}, OutB, exp);
  endtask

  task automatic sweep_model(input string tag);
    Reset = 1'b0; RegSel = 4'b0; ScrSel = 4'b0;
    for (int k = 0; k < 8; k++) begin
      OutASel = 3'(k); OutBSel = 3'(7 - k);
      #1;
      check({tag, "_a"}, OutA, m[k]);
      check({tag, "_b"}, OutB, m[7 - k]);
    end
  endtask

  initial begin
    Reset = 1'b1; I = '0; FunSel = 3'b0; RegSel = 4'b0; ScrSel = 4'b0;
    OutASel = 3'b0; OutBSel = 3'b0;

    // Reset then read every register.
    @(posedge Clock);
    for (int k = 0; k < 8; k++) m[k] = 0;
    #1;
    for (int k = 0; k < 8; k++) read_check("reset_sweep", 3'(k), 32'h0);

    // Load, sign-extend, zero-extend.
    apply(1'b0, 3'b010, 4'b0001, 4'b0000, 32'h0000_8001);
    apply(1'b0, 3'b110, 4'b0000, 4'b0010, 32'h0000_8001);
    apply(1'b0, 3'b101, 4'b0100, 4'b0000, 32'h1234_8001);
    read_check("load_r1", 3'd0, 32'h0000_8001);
    read_check("sext_s2", 3'd5, 32'hffff_8001);
    read_check("zext_r3", 3'd2, 32'h0000_8001);
    apply(1'b0, 3'b100, 4'b0000, 4'b0001, 32'hcafe_f0a5);
    read_check("byte_s1", 3'd4, 32'h0000_00a5);

    // Wrap-around on R2.
    apply(1'b0, 3'b011, 4'b0010, 4'b0000, 32'hffff_ffff);
    apply(1'b0, 3'b000, 4'b0010, 4'b0000, 32'h0);
    read_check("dec_wrap", 3'd1, 32'hffff_ffff);
    apply(1'b0, 3'b001, 4'b0010, 4'b0000, 32'h0);
    read_check("inc_wrap", 3'd1, 32'h0);

    // Byte assembly into S4.
    apply(1'b0, 3'b011, 4'b0000, 4'b1000, 32'h0);
    apply(1'b0, 3'b111, 4'b0000, 4'b1000, 32'h0000_00de);
    apply(1'b0, 3'b111, 4'b0000, 4'b1000, 32'h0000_00ad);
    apply(1'b0, 3'b111, 4'b0000, 4'b1000, 32'h0000_00be);
    apply(1'b0, 3'b111, 4'b0000, 4'b1000, 32'h0000_00ef);
    read_check("shift_word", 3'd7, 32'hdead_beef);

    // Reset mid-assembly abandons the sequence and clears everything.
    apply(1'b0, 3'b011, 4'b0000, 4'b1000, 32'h0);
    apply(1'b0, 3'b111, 4'b0000, 4'b1000, 32'h0000_00de);
    apply(1'b0, 3'b111, 4'b0000, 4'b1000, 32'h0000_00ad);
    apply(1'b1, 3'b111, 4'b1111, 4'b1000, 32'h0000_00be);
    read_check("shift_reset", 3'd7, 32'h0);
    read_check("reset_r1", 3'd0, 32'h0);
    apply(1'b0, 3'b111, 4'b0000, 4'b1000, 32'h0000_0011);
    read_check("shift_restart", 3'd7, 32'h0000_0011);

    // Parallel write and isolation.
    apply(1'b0, 3'b010, 4'b0001, 4'b0000, 32'd5);
    apply(1'b0, 3'b010, 4'b1000, 4'b0000, 32'd9);
    apply(1'b0, 3'b010, 4'b0010, 4'b0001, 32'h55);
    apply(1'b0, 3'b001, 4'b1001, 4'b0000, 32'hffff_ffff);
    read_check("par_r1", 3'd0, 32'd6);
    read_check("par_r4", 3'd3, 32'd10);
    read_check("iso_r2", 3'd1, 32'h55);
    read_check("iso_r3", 3'd2, 32'h0);
    read_check("iso_s1", 3'd4, 32'h55);
    read_check("iso_s4", 3'd7, 32'h11);
    apply(1'b0, 3'b011, 4'b0000, 4'b0000, 32'h0);
    read_check("noen_r1", 3'd0, 32'd6);
    read_check("noen_s1", 3'd4, 32'h55);

    // Read-during-write on R1.
    apply(1'b0, 3'b010, 4'b0001, 4'b0000, 32'h10);
    Reset = 1'b0; FunSel = 3'b010; I = 32'h20; RegSel = 4'b0001; ScrSel = 4'b0;
    OutASel = 3'd0; OutBSel = 3'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_same_cycle", OutA, 32'h20);
`else
    check("rdw_same_cycle", OutA, 32'h10);
`endif
    @(posedge Clock);
    model_step();
    #1;
    RegSel = 4'b0;
    #1;
    check("rdw_after_edge", OutA, 32'h20);

    // Randomized operations against the model.
    for (int n = 0; n < 300; n++) begin
      apply(($urandom_range(0, 24) == 0), 3'($urandom), 4'($urandom), 4'($urandom), $urandom);
    end
    sweep_model("final_sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
